// File: rtl/stopwatch_bcd_counter.sv
// Two-digit BCD stopwatch counter with an internal prescaler, loads, and wrap/expiry flags.
// Latency: loads and count steps are visible one cycle after the sampling edge; all outputs registered.
// Backpressure: none; enable=0 freezes prescaler and digits, loads always act.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high clear of all state
//   enable       1 = prescaler runs and counting proceeds, 0 = hold
//   up           count direction (1 = up, 0 = down), sampled at each step
//   load0/1      synchronous digit loads (values above 9 clamp to 9)
//   load0/1_value digit values to load
//   q0, q1       units and tens BCD digits
//   tick         one-cycle pulse aligned with a count step on q0/q1
//   wrap         one-cycle pulse on an up step from 99 to 00
//   done         one-cycle pulse on a down step from 01 to 00
module stopwatch_bcd_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       load0,
  input  logic [3:0] load0_value,
  input  logic       load1,
  input  logic [3:0] load1_value,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic       tick,
  output logic       wrap,
  output logic       done
);

  // TICK_DIV=1 still needs a one-bit prescaler; it simply never leaves 0.
  localparam int              PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_p;
  logic [3:0]    r_q0;
  logic [3:0]    r_q1;
  logic          r_tick;
  logic          r_wrap;
  logic          r_done;

  logic [PW-1:0] w_p_nxt;
  logic [3:0]    w_q0_nxt;
  logic [3:0]    w_q1_nxt;
  logic          w_tick_nxt;
  logic          w_wrap_nxt;
  logic          w_done_nxt;
  logic          w_load;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign w_load = load0 | load1;

  always_comb begin
    w_p_nxt    = r_p;
    w_q0_nxt   = r_q0;
    w_q1_nxt   = r_q1;
    w_tick_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    w_done_nxt = 1'b0;

    if (w_load) begin
      // A load restarts the count interval so the next step is a full period away.
      if (load0) w_q0_nxt = clamp9(load0_value);
      if (load1) w_q1_nxt = clamp9(load1_value);
      w_p_nxt = '0;
    end else if (enable) begin
      if (r_p == P_LAST) begin
        w_p_nxt    = '0;
        w_tick_nxt = 1'b1;
        if (up) begin
          if (r_q0 != 4'd9) begin
            w_q0_nxt = r_q0 + 4'd1;
          end else begin
            w_q0_nxt = 4'd0;
            if (r_q1 != 4'd9) begin
              w_q1_nxt = r_q1 + 4'd1;
            end else begin
              w_q1_nxt   = 4'd0;
              w_wrap_nxt = 1'b1;
            end
          end
        end else begin
          if (r_q0 != 4'd0) begin
            w_q0_nxt   = r_q0 - 4'd1;
            w_done_nxt = (r_q1 == 4'd0) && (r_q0 == 4'd1);
          end else if (r_q1 != 4'd0) begin
            w_q0_nxt = 4'd9;
            w_q1_nxt = r_q1 - 4'd1;
          end
          // At 00 the digits saturate; tick still fires but done does not.
        end
      end else begin
        w_p_nxt = r_p + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p    <= '0;
      r_q0   <= 4'd0;
      r_q1   <= 4'd0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_p    <= w_p_nxt;
      r_q0   <= w_q0_nxt;
      r_q1   <= w_q1_nxt;
      r_tick <= w_tick_nxt;
      r_wrap <= w_wrap_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign q0   = r_q0;
  assign q1   = r_q1;
  assign tick = r_tick;
  assign wrap = r_wrap;
  assign done = r_done;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter with TICK_DIV=4.
// Driver pushes the model's expected post-edge outputs into a queue; a monitor pops one per edge.
// Directed scenarios first, then randomized stimulus.
module tb_stopwatch_bcd_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up;
  logic       load0;
  logic [3:0] load0_value;
  logic       load1;
  logic [3:0] load1_value;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       tick;
  logic       wrap;
  logic       done;

  stopwatch_bcd_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up),
    .load0(load0), .load0_value(load0_value),
    .load1(load1), .load1_value(load1_value),
    .q0(q0), .q1(q1), .tick(tick), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q0;
    int q1;
    int tick;
    int wrap;
    int done;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: the counter value as a plain integer 0..99 plus phase count.
  int m_val = 0;
  int m_ph  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit u,
                            input bit l0, input int v0, input bit l1, input int v1);
    exp_t e;
    int d0, d1;
    e.tick = 0; e.wrap = 0; e.done = 0;
    if (rst) begin
      m_val = 0; m_ph = 0;
    end else if (l0 || l1) begin
      d0 = l0 ? clampv(v0) : (m_val % 10);
      d1 = l1 ? clampv(v1) : (m_val / 10);
      m_val = d1 * 10 + d0;
      m_ph  = 0;
    end else if (en) begin
      if (m_ph == TD - 1) begin
        m_ph = 0;
        e.tick = 1;
        if (u) begin
          if (m_val == 99) begin m_val = 0; e.wrap = 1; end
          else m_val = m_val + 1;
        end else if (m_val > 0) begin
          if (m_val == 1) e.done = 1;
          m_val = m_val - 1;
        end
      end else begin
        m_ph = m_ph + 1;
      end
    end
    e.q0 = m_val % 10;
    e.q1 = m_val / 10;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs just after an edge; they are sampled at the next edge.
  task automatic cyc(input bit rst, input bit en, input bit u,
                     input bit l0, input int v0, input bit l1, input int v1);
    @(posedge clk);
    #2;
    reset = rst; enable = en; up = u;
    load0 = l0; load0_value = 4'(v0);
    load1 = l1; load1_value = 4'(v1);
    model_step(rst, en, u, l0, v0, l1, v1);
  endtask

  task automatic run(input int n, input bit en, input bit u);
    for (int i = 0; i < n; i++) cyc(0, en, u, 0, 0, 0, 0);
  endtask

  // Assert reset between edges and confirm the outputs clear before any clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #2;
    reset = 1'b1; enable = 1'b0; load0 = 1'b0; load1 = 1'b0;
    #1;
    chk("async_q0", int'(q0), 0);
    chk("async_q1", int'(q1), 0);
    chk("async_tick", int'(tick), 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every edge the DUT presents fresh outputs; compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q0", int'(q0), e.q0);
        chk("q1", int'(q1), e.q1);
        chk("tick", int'(tick), e.tick);
        chk("wrap", int'(wrap), e.wrap);
        chk("done", int'(done), e.done);
      end
    end
  end

  initial begin
    bit u_r;
    int r;
    reset = 1'b1; enable = 1'b0; up = 1'b1;
    load0 = 1'b0; load0_value = 4'd0; load1 = 1'b0; load1_value = 4'd0;

    // Reset held across edges.
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);

    // Async reset mid-interval after loading 57 and counting.
    cyc(0, 1, 1, 1, 7, 1, 5);
    run(10, 1, 1);
    async_reset_check();
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    run(5, 1, 1);

    // Up wrap from 98.
    cyc(0, 1, 1, 1, 8, 1, 9);
    run(9, 1, 1);

    // Down expiry from 02 and saturation at 00.
    cyc(0, 1, 0, 1, 2, 1, 0);
    run(13, 1, 0);

    // Clamp and partial loads.
    cyc(0, 0, 1, 0, 0, 1, 3);
    cyc(0, 0, 1, 1, 12, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 15);
    cyc(0, 1, 1, 1, 10, 1, 14);

    // Pause preserves phase.
    cyc(0, 0, 1, 1, 0, 1, 0);
    run(2, 1, 1);
    run(10, 0, 1);
    run(3, 1, 1);

    // Load colliding with a step edge.
    cyc(0, 0, 1, 1, 3, 1, 4);
    run(3, 1, 1);
    cyc(0, 1, 1, 1, 5, 0, 0);
    run(5, 1, 1);

    // Direction change mid-interval.
    run(2, 1, 1);
    run(6, 1, 0);

    // Randomized stimulus.
    u_r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 199);
      if ($urandom_range(0, 19) == 0) u_r = ~u_r;
      if (r == 0) begin
        cyc(1, 1, u_r, 0, 0, 0, 0);
      end else if (r <= 10) begin
        cyc(0, ($urandom_range(0, 1) == 1), u_r,
            (r <= 7), $urandom_range(0, 15),
            (r >= 4), $urandom_range(0, 15));
      end else begin
        cyc(0, ($urandom_range(0, 4) != 0), u_r, 0, 0, 0, 0);
      end
    end

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Two-digit BCD counter datapath for the stopwatch. It sits directly downstream of the stopwatch control FSM: it consumes that FSM's reset/enable/up/load commands and produces the q0 (units) and q1 (tens) digits the FSM reads back for its add-5 arithmetic. An internal prescaler turns the fast system clock into count steps, and the counter flags up-count wrap and down-count expiry.

## Interface
- TICK_DIV, default 50_000_000: enabled clock cycles per count step; legal range ≥ 1.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  1 = prescaler runs and counting proceeds; 0 = pause, all state held.
- up  in  1  1 = count up, 0 = count down; sampled at each step.
- load0  in  1  synchronous load of q0 from load0_value, active-high.
- load0_value  in  4  units digit to load.
- load1  in  1  synchronous load of q1 from load1_value, active-high.
- load1_value  in  4  tens digit to load.
- q0  out  4  units BCD digit, 0–9, registered.
- q1  out  4  tens BCD digit, 0–9, registered.
- tick  out  1  one-cycle pulse, high in the cycle a count step becomes visible on q0/q1.
- wrap  out  1  one-cycle pulse on an up-count step from 99 to 00.
- done  out  1  one-cycle pulse on a down-count step from 01 to 00.
- One clock; reset is asynchronous and active-high.

## Operation
- Prescaler p: width max(1, $clog2(TICK_DIV)), counts 0..TICK_DIV-1.
- Priority at each edge: reset (async) > any load > count step > hold.
- Load: when load0 or load1 is high, the asserted digit(s) take their value and an unasserted digit holds. p is cleared to 0; tick, wrap and done stay 0 that cycle. Loads act regardless of enable.
- Load clamp: a load value of 10–15 loads 9.
- Step condition: enable=1, no load, and p==TICK_DIV-1. Then p←0, tick←1, and the digits step. Otherwise, with enable=1, p←p+1.
- Up step: q0<9 → q0+1. q0=9 → q0=0 and q1+1. 99 → 00 with wrap=1.
- Down step: q0>0 → q0-1. q0=0 and q1>0 → q0=9 and q1-1. 01 → 00 with done=1.
- Down at 00: the counter saturates. q holds, tick still pulses, done stays 0.
- enable=0: p, q0 and q1 hold. Prescaler phase is preserved, not cleared.
- Changing up mid-interval takes effect at the next step; p is not disturbed.
- Reset values: q0=0, q1=0, p=0, tick=0, wrap=0, done=0.

## Timing
- All outputs come from flops; there is no combinational input-to-output path.
- Load latency: 1 cycle. The new digit is visible after the edge where load is sampled high.
- Steps occur every TICK_DIV enabled cycles. The first step after reset or load comes at the TICK_DIV-th enabled edge.
- tick, wrap and done are high for exactly one cycle, aligned with the updated q0/q1.
- Reset asserted mid-interval clears q0/q1/p asynchronously, without waiting for a clock edge. The first step after release comes TICK_DIV enabled edges later.
- TICK_DIV=1: a step occurs on every enabled cycle with no load, and tick stays high continuously.

## Test plan
All scenarios use TICK_DIV=4.
- Async reset: load 57, count a few steps, assert reset between edges → q0=0, q1=0, tick=0 before the next clk edge. Hold reset for 3 edges → q stays 00.
- Up wrap: load 98, up=1, enable=1 → q=99 after edge 4, q=00 with wrap=1 and tick=1 after edge 8; wrap=0 on edge 9.
- Down expiry: load 02, up=0, enable=1 → 01 at edge 4, 00 with done=1 at edge 8. Edge 12: q stays 00, tick=1, done=0.
- Load clamp and partial load: load0=1, load0_value=12 with q1=3 → q0=9, q1=3. Then load1=1, load1_value=15 → q1=9, q0=9.
- Pause: enable=1 for 2 edges (p=2), enable=0 for 10 edges → q, p and tick unchanged. Re-enable → tick on the 2nd enabled edge.
- Load vs step collision: assert load0=1, load0_value=5 on the edge where p==3 → q0=5, tick=0, p=0. The next tick comes 4 edges later.
